// File: rtl/idu_if.sv
// idu_if: handshake bundle around idu_stage (fetch -> decode -> execute).
// Handshake rule on both sides: a transfer occurs on a rising clk edge where
// valid and ready are both 1; valid never depends on ready, and the
// consumer's ready may depend combinationally on its own downstream ready.
interface idu_if #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
);
    logic                 ifu_valid;
    logic [31:0]          ifu_inst;
    logic [XLEN-1:0]      ifu_pc;
    logic                 idu_ready;
    logic                 exu_ready;
    logic                 exu_valid;
    logic [XLEN-1:0]      exu_pc;
    logic [RF_ADDR_W-1:0] rs1_addr;
    logic [RF_ADDR_W-1:0] rs2_addr;
    logic [RF_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]      imm;
    logic [3:0]           alu_op;
    logic                 alu_src_b_imm;
    logic                 rf_wen;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [1:0]           mem_size;
    logic                 mem_unsigned;
    logic                 is_branch;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 is_auipc;
    logic                 is_ebreak;
    logic                 illegal;

    // Decode stage side
    modport slave (
        input  ifu_valid, ifu_inst, ifu_pc, exu_ready,
        output idu_ready, exu_valid, exu_pc, rs1_addr, rs2_addr, rd_addr,
               imm, alu_op, alu_src_b_imm, rf_wen, mem_ren, mem_wen,
               mem_size, mem_unsigned, is_branch, is_jal, is_jalr,
               is_auipc, is_ebreak, illegal
    );

    // Surrounding pipeline side (fetch producer + execute consumer)
    modport master (
        output ifu_valid, ifu_inst, ifu_pc, exu_ready,
        input  idu_ready, exu_valid, exu_pc, rs1_addr, rs2_addr, rd_addr,
               imm, alu_op, alu_src_b_imm, rf_wen, mem_ren, mem_wen,
               mem_size, mem_unsigned, is_branch, is_jal, is_jalr,
               is_auipc, is_ebreak, illegal
    );
endinterface

// File: rtl/idu_stage.sv
// idu_stage: RV32I instruction decode with a one-entry output register.
// Optional macro IDU_PERF_CNT_EN adds perf_inst_cnt / perf_stall_cnt outputs.
// RF_ADDR_W=4 selects RV32E: any used register index >= 16 is illegal.
module idu_stage #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    idu_if.slave        bus,
    output logic        dbg_state
`ifdef IDU_PERF_CNT_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam bit NARROW_RF = (RF_ADDR_W < 5);

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      imm;
        logic [3:0]           alu_op;
        logic                 src_b_imm;
        logic                 rf_wen;
        logic                 mem_ren;
        logic                 mem_wen;
        logic [1:0]           mem_size;
        logic                 mem_unsigned;
        logic                 is_branch;
        logic                 is_jal;
        logic                 is_jalr;
        logic                 is_auipc;
        logic                 is_ebreak;
        logic                 illegal;
    } dec_t;

    logic [0:0]      state;
    logic            accept;
    dec_t            dec;
    dec_t            dec_q;
    logic [XLEN-1:0] pc_q;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [31:0] imm32;
    logic [3:0]  alu_op;
    logic        src_b_imm, wr_rd, is_ld, is_st, br, jal, jalr, auipc, ebreak, bad;
    logic        use_rs1, use_rs2;
    logic [1:0]  msize;
    logic        munsigned;

    assign inst   = bus.ifu_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Combinational RV32I decode of the word currently offered by fetch
    always_comb begin
        imm32     = '0;
        alu_op    = ALU_ADD;
        src_b_imm = 1'b0;
        wr_rd     = 1'b0;
        is_ld     = 1'b0;
        is_st     = 1'b0;
        br        = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        auipc     = 1'b0;
        ebreak    = 1'b0;
        bad       = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        msize     = 2'b00;
        munsigned = 1'b0;
        case (opcode)
            OP_LUI: begin
                imm32 = imm_u; alu_op = ALU_PASS_B; src_b_imm = 1'b1; wr_rd = 1'b1;
            end
            OP_AUIPC: begin
                imm32 = imm_u; src_b_imm = 1'b1; wr_rd = 1'b1; auipc = 1'b1;
            end
            OP_JAL: begin
                imm32 = imm_j; src_b_imm = 1'b1; wr_rd = 1'b1; jal = 1'b1;
            end
            OP_JALR: begin
                imm32 = imm_i; src_b_imm = 1'b1; wr_rd = 1'b1; jalr = 1'b1;
                use_rs1 = 1'b1; bad = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                imm32 = imm_b; br = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                imm32 = imm_i; src_b_imm = 1'b1; wr_rd = 1'b1; is_ld = 1'b1; use_rs1 = 1'b1;
                msize = funct3[1:0]; munsigned = funct3[2];
                bad = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
            end
            OP_STORE: begin
                imm32 = imm_s; src_b_imm = 1'b1; is_st = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                msize = funct3[1:0];
                bad = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OP_IMM: begin
                imm32 = imm_i; src_b_imm = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b001: begin alu_op = ALU_SLL; bad = (funct7 != 7'b0000000); end
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: begin
                        alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OP_REG: begin
                wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                // funct7=0100000 is only meaningful for SUB and SRA
                bad = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                case (funct3)
                    3'b000: alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OP_FENCE: begin
                bad = (funct3 != 3'b000);
            end
            OP_SYSTEM: begin
                // Only ECALL and EBREAK exist in the base ISA; both have no side effects here
                if (inst == 32'h0010_0073) ebreak = 1'b1;
                else if (inst != 32'h0000_0073) bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // RV32E: bit 4 of any register index actually used by the format is out of range
        if (NARROW_RF) begin
            bad = bad | (use_rs1 & inst[19]) | (use_rs2 & inst[24]) | (wr_rd & inst[11]);
        end
    end

    // Pack decode results; side effects are suppressed for illegal words and rd==x0
    always_comb begin
        dec              = '0;
        dec.rs1          = inst[15 +: RF_ADDR_W];
        dec.rs2          = inst[20 +: RF_ADDR_W];
        dec.rd           = inst[7 +: RF_ADDR_W];
        dec.imm          = XLEN'($signed(imm32));
        dec.alu_op       = alu_op;
        dec.src_b_imm    = src_b_imm;
        dec.rf_wen       = wr_rd && (inst[11:7] != 5'd0) && !bad;
        dec.mem_ren      = is_ld && !bad;
        dec.mem_wen      = is_st && !bad;
        dec.mem_size     = msize;
        dec.mem_unsigned = munsigned;
        dec.is_branch    = br;
        dec.is_jal       = jal;
        dec.is_jalr      = jalr;
        dec.is_auipc     = auipc;
        dec.is_ebreak    = ebreak;
        dec.illegal      = bad;
    end

    // Ready looks only at our own state and the downstream ready, never at ifu_valid
    assign bus.idu_ready = (state == S_EMPTY) || bus.exu_ready;
    assign accept        = bus.ifu_valid && bus.idu_ready;

    // EMPTY/FULL occupancy of the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else if (accept) begin
            state <= S_FULL;
        end else if ((state == S_FULL) && bus.exu_ready) begin
            state <= S_EMPTY;
        end
    end

    // Output register captures the decode result on every accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= '0;
            pc_q  <= '0;
        end else if (accept) begin
            dec_q <= dec;
            pc_q  <= bus.ifu_pc;
        end
    end

    assign bus.exu_valid     = (state == S_FULL);
    assign bus.exu_pc        = pc_q;
    assign bus.rs1_addr      = dec_q.rs1;
    assign bus.rs2_addr      = dec_q.rs2;
    assign bus.rd_addr       = dec_q.rd;
    assign bus.imm           = dec_q.imm;
    assign bus.alu_op        = dec_q.alu_op;
    assign bus.alu_src_b_imm = dec_q.src_b_imm;
    assign bus.rf_wen        = dec_q.rf_wen;
    assign bus.mem_ren       = dec_q.mem_ren;
    assign bus.mem_wen       = dec_q.mem_wen;
    assign bus.mem_size      = dec_q.mem_size;
    assign bus.mem_unsigned  = dec_q.mem_unsigned;
    assign bus.is_branch     = dec_q.is_branch;
    assign bus.is_jal        = dec_q.is_jal;
    assign bus.is_jalr       = dec_q.is_jalr;
    assign bus.is_auipc      = dec_q.is_auipc;
    assign bus.is_ebreak     = dec_q.is_ebreak;
    assign bus.illegal       = dec_q.illegal;
    assign dbg_state         = state[0];

`ifdef IDU_PERF_CNT_EN
    // Handshake and stall counters on the execute side, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_inst_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bus.exu_valid && bus.exu_ready)  perf_inst_cnt  <= perf_inst_cnt + 32'd1;
            if (bus.exu_valid && !bus.exu_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
